cmd_mem_loader: RTL
===================

Name: cmd_mem_loader

Overview:
- Write-side front end for the per-core command memories.
- Accepts a 32-bit word stream from the host/DMA, parses a two-word header, and packs MEM_TO_CMD words into one CMD_WIDTH command per address.
- Writes each command into the command memory of the selected core, one address per command, with auto-incrementing address.
- Replaces the flat one-write-per-command port with a multi-core, bounds-checked, stream-driven loader.

Parameters:
N_CORES, 8, number of processor cores / command memories served
MEM_WIDTH, 32, stream word width and command-memory bank width
MEM_TO_CMD, 4, stream words per command
CMD_WIDTH, MEM_WIDTH*MEM_TO_CMD, command width
CMD_ADDR_WIDTH, 16, command memory address width; requires CMD_ADDR_WIDTH < MEM_WIDTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
s_data  in  MEM_WIDTH  stream word
s_valid  in  1  stream word valid
s_ready  out  1  loader accepts a word this cycle
mem_hold  in  1  memory-side stall; forces s_ready low
abort  in  1  synchronous abort of the current transfer
wr_enable  out  N_CORES  one-hot write enable per core memory
wr_addr  out  CMD_ADDR_WIDTH  write address, shared by all cores
wr_data  out  CMD_WIDTH  packed command, shared by all cores
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse: transfer completed or drained
err  out  1  one-cycle pulse, coincident with done, when the header was rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; wr_enable, wr_addr, wr_data, done, err, busy = 0.
  - Word counter, address, remaining-command counter and pack register cleared.
  - s_ready=0 while in reset.
- Handshake:
  - s_ready = reset & ~mem_hold in every state.
  - A word is accepted on a rising edge with s_valid & s_ready; nothing advances otherwise.
- States:
  - IDLE:
    - Accepted word is header0: start_addr = s_data[CMD_ADDR_WIDTH-1:0], core_id = s_data[MEM_WIDTH-1:CMD_ADDR_WIDTH].
    - Go to HDR1.
  - HDR1:
    - Accepted word is count (unsigned MEM_WIDTH).
    - Bad header if core_id >= N_CORES, or start_addr + count > 2^CMD_ADDR_WIDTH (computed in MEM_WIDTH+1 bits).
    - count=0 and header good: go to IDLE; done pulses next cycle; no writes.
    - count=0 and header bad: go to IDLE; done and err pulse next cycle.
    - count>0 and header good: go to LOAD.
    - count>0 and header bad: go to DRAIN with count*MEM_TO_CMD words to discard.
  - LOAD:
    - Accepted word k (k = 0..MEM_TO_CMD-1) is stored at pack bits [MEM_WIDTH*(k+1)-1 : MEM_WIDTH*k]; word 0 is the LSBs.
    - On accepting word MEM_TO_CMD-1, the next cycle has:
      - wr_enable[core_id] = 1 for exactly one cycle;
      - wr_addr = current address;
      - wr_data = the full packed command, including the final word.
    - Then address increments and remaining count decrements.
    - After the last command: go to IDLE; done pulses in the same cycle as that final wr_enable.
  - DRAIN:
    - Discard accepted words, with no write enables.
    - After the final word: go to IDLE; done and err pulse next cycle.
- Latency: last word of a command accepted at edge N; write visible in the cycle after edge N, sampled by memory at edge N+1.
- Back-to-back commands: full throughput, one word per cycle; no bubbles between commands or between transfers (header0 may follow immediately after the last payload word).
- wr_addr and wr_data hold their last values when wr_enable=0.
- Address arithmetic: never wraps. The bounds check at HDR1 guarantees the final address is <= 2^CMD_ADDR_WIDTH-1.
- abort:
  - In any state: next state IDLE; partial pack discarded, no write issued.
  - done and err both pulse if busy was high; nothing pulses in IDLE.
  - abort overrides a simultaneous accept, which is dropped.
  - If abort coincides with the cycle issuing a write, that write still completes.
- mem_hold mid-command: pack and counters hold; resume with the next word, no data loss.
- busy = (state != IDLE).

Test Plan:
- Words {0x0002_0010, 2, A0..A3, B0..B3} -> wr_enable=0x04 at wr_addr 0x10 with data {A3,A2,A1,A0}, then at 0x11 with {B3,B2,B1,B0}; done with second write; no err.
- Header core_id=8 (N_CORES=8), count=3 -> 12 payload words drained, wr_enable stays 0, done+err pulse once; next header is parsed correctly.
- start_addr=0xFFFF, count=1 -> write at 0xFFFF. start_addr=0xFFFF, count=2 -> DRAIN of 8 words, err.
- count=0 -> done one cycle after header1, no writes, no err.
- Abort after 2 payload words -> no write; done+err pulse; next transfer's command starts clean at word 0.
- Random mem_hold and s_valid gaps over 64 commands to core 5 -> memory image matches the expected one, addresses contiguous; back-to-back transfer with no idle cycle works.

Source files
------------

// File: rtl/cmd_mem_loader_if.sv
// Stream-in / command-memory-write bundle for the command memory loader.
// The host side drives the stream and control; the loader drives ready, writes and status.
interface cmd_mem_loader_if #(
    parameter int N_CORES        = 8,
    parameter int MEM_WIDTH      = 32,
    parameter int MEM_TO_CMD     = 4,
    parameter int CMD_ADDR_WIDTH = 16
);
    localparam int CMD_WIDTH = MEM_WIDTH * MEM_TO_CMD;

    logic [MEM_WIDTH-1:0]      s_data;
    logic                      s_valid;
    logic                      s_ready;
    logic                      mem_hold;
    logic                      abort;
    logic [N_CORES-1:0]        wr_enable;
    logic [CMD_ADDR_WIDTH-1:0] wr_addr;
    logic [CMD_WIDTH-1:0]      wr_data;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport master (
        output s_data, s_valid, mem_hold, abort,
        input  s_ready, wr_enable, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  s_data, s_valid, mem_hold, abort,
        output s_ready, wr_enable, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/cmd_mem_loader.sv
// Stream-driven loader: parses {core_id,start_addr} and count headers, packs
// MEM_TO_CMD words per command and writes them to the selected core's memory.
module cmd_mem_loader #(
    parameter int N_CORES        = 8,
    parameter int MEM_WIDTH      = 32,
    parameter int MEM_TO_CMD     = 4,
    parameter int CMD_WIDTH      = MEM_WIDTH * MEM_TO_CMD,
    parameter int CMD_ADDR_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    cmd_mem_loader_if.slave   bus
);
    localparam int CORE_WIDTH = MEM_WIDTH - CMD_ADDR_WIDTH;
    localparam int WC_WIDTH   = (MEM_TO_CMD > 1) ? $clog2(MEM_TO_CMD) : 1;
    localparam logic [WC_WIDTH-1:0]  LAST_WORD  = WC_WIDTH'(MEM_TO_CMD - 1);
    localparam logic [MEM_WIDTH:0]   ADDR_SPACE = (MEM_WIDTH + 1)'(1) << CMD_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, HDR1, LOAD, DRAIN} state_t;

    state_t                    state_reg, state_next;
    logic [CORE_WIDTH-1:0]     core_id_reg, core_id_next;
    logic [CMD_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [MEM_WIDTH-1:0]      remaining_reg, remaining_next;
    logic [WC_WIDTH-1:0]       word_cnt_reg, word_cnt_next;
    logic [N_CORES-1:0]        wr_enable_reg, wr_enable_next;
    logic [CMD_ADDR_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [CMD_WIDTH-1:0]      wr_data_reg, wr_data_next;
    logic                      done_reg, done_next;
    logic                      err_reg, err_next;

    // Only the leading words are stored; the final word goes straight into wr_data.
    logic [MEM_WIDTH-1:0]      pack_reg [MEM_TO_CMD-1];
    logic [CMD_WIDTH-1:0]      cmd_full;
    logic                      accept;
    logic                      store_word;
    logic [MEM_WIDTH:0]        end_addr;
    logic                      header_bad;

    assign bus.s_ready = reset & ~bus.mem_hold;
    assign accept      = bus.s_valid & bus.s_ready;
    assign store_word  = accept & ~bus.abort & (state_reg == LOAD);

    // One-bit-wider sum so start_addr + count cannot overflow the check.
    assign end_addr   = (MEM_WIDTH + 1)'(addr_reg) + (MEM_WIDTH + 1)'(bus.s_data);
    assign header_bad = (MEM_WIDTH'(core_id_reg) >= MEM_WIDTH'(N_CORES)) || (end_addr > ADDR_SPACE);

    generate
        for (genvar gi = 0; gi < MEM_TO_CMD - 1; gi++) begin : g_pack
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pack_reg[gi] <= '0;
                end else if (store_word && word_cnt_reg == WC_WIDTH'(gi)) begin
                    pack_reg[gi] <= bus.s_data;
                end
            end
            assign cmd_full[gi*MEM_WIDTH +: MEM_WIDTH] = pack_reg[gi];
        end
    endgenerate
    assign cmd_full[CMD_WIDTH-1 -: MEM_WIDTH] = bus.s_data;

    always_comb begin
        state_next     = state_reg;
        core_id_next   = core_id_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        word_cnt_next  = word_cnt_reg;
        wr_enable_next = '0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;

        if (bus.abort) begin
            state_next    = IDLE;
            word_cnt_next = '0;
            done_next     = (state_reg != IDLE);
            err_next      = (state_reg != IDLE);
        end else if (accept) begin
            case (state_reg)
                IDLE: begin
                    addr_next    = bus.s_data[CMD_ADDR_WIDTH-1:0];
                    core_id_next = bus.s_data[MEM_WIDTH-1 -: CORE_WIDTH];
                    state_next   = HDR1;
                end
                HDR1: begin
                    remaining_next = bus.s_data;
                    word_cnt_next  = '0;
                    if (bus.s_data == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        err_next   = header_bad;
                    end else begin
                        state_next = header_bad ? DRAIN : LOAD;
                    end
                end
                LOAD: begin
                    if (word_cnt_reg == LAST_WORD) begin
                        word_cnt_next  = '0;
                        wr_enable_next = N_CORES'(1) << core_id_reg;
                        wr_addr_next   = addr_reg;
                        wr_data_next   = cmd_full;
                        // The final command leaves the address in place so it never wraps.
                        if (remaining_reg == MEM_WIDTH'(1)) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            addr_next      = addr_reg + 1'b1;
                            remaining_next = remaining_reg - 1'b1;
                        end
                    end else begin
                        word_cnt_next = word_cnt_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    if (word_cnt_reg == LAST_WORD) begin
                        word_cnt_next = '0;
                        if (remaining_reg == MEM_WIDTH'(1)) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                            err_next   = 1'b1;
                        end else begin
                            remaining_next = remaining_reg - 1'b1;
                        end
                    end else begin
                        word_cnt_next = word_cnt_reg + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            core_id_reg   <= '0;
            addr_reg      <= '0;
            remaining_reg <= '0;
            word_cnt_reg  <= '0;
            wr_enable_reg <= '0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            core_id_reg   <= core_id_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            word_cnt_reg  <= word_cnt_next;
            wr_enable_reg <= wr_enable_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign bus.wr_enable = wr_enable_reg;
    assign bus.wr_addr   = wr_addr_reg;
    assign bus.wr_data   = wr_data_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule
